// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the input debouncer.
// Channel FSM states plus counter sizing used by every channel.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  // Bits needed to hold 0..n inclusive, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: level FSM, debounce counter, hold counter.
// Takes a polarity-corrected, already synchronized level.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES     = 20000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W  = cnt_width(STABLE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE =
    HOLD_W'((LONG_PRESS_CYCLES > 0) ? LONG_PRESS_CYCLES - 1 : 0);
  localparam bit LONG_EN = (LONG_PRESS_CYCLES > 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  logic              long_hit;

  // Saturating hold step and the one-shot long-press condition.
  always_comb begin
    hold_next = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);
    long_hit  = LONG_EN && (hold == HOLD_FIRE);
  end

  // Channel FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE_LOW;
      cnt           <= '0;
      hold          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      unique case (state)
        IDLE_LOW: begin
          if (x) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!x) begin
            state <= IDLE_LOW;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            level <= 1'b1;
            press <= 1'b1;
            hold  <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          hold       <= hold_next;
          long_press <= long_hit;
          if (!x) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (x) begin
            state      <= IDLE_HIGH;
            hold       <= hold_next;
            long_press <= long_hit;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE_LOW;
            level         <= 1'b0;
            release_pulse <= 1'b1;
            hold          <= '0;
          end else begin
            cnt        <= cnt + CNT_ONE;
            hold       <= hold_next;
            long_press <= long_hit;
          end
        end
        default: state <= IDLE_LOW;
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel debouncer with press/release/long-press pulses.
// Inputs must already be synchronized; channels are independent.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   CHANNELS          = 4,
  parameter int   STABLE_CYCLES     = 20000,
  parameter int   LONG_PRESS_CYCLES = 50000000,
  parameter logic ACTIVE_LOW        = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sync_in,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_press_o
);

  logic [CHANNELS-1:0] x;

  // Normalise polarity so channels always see 1 = pressed.
  always_comb begin
    x = sync_in ^ {CHANNELS{ACTIVE_LOW}};
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES    (STABLE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .x            (x[i]),
      .level        (level_o[i]),
      .press        (press_o[i]),
      .release_pulse(release_o[i]),
      .long_press   (long_press_o[i])
    );
  end

endmodule
